// File: rtl/neuron_mac.sv
// Sequential signed multiply-accumulate with per-beat saturation, feeding the
// neuron's bias adder through a valid/ready handshake.
module neuron_mac #(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] w,
   output logic [ACC_W-1:0]  acc_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              overflow
);

   localparam int CNT_W  = $clog2(N_INPUTS + 1);
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                  state_reg;
   state_t                  state_next;
   logic [ACC_W-1:0]        acc_reg;
   logic [CNT_W-1:0]        count_reg;
   logic                    overflow_reg;

   logic                    beat;
   logic                    last_beat;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W:0]   acc_ext;
   logic signed [ACC_W:0]   prod_ext;
   logic signed [ACC_W:0]   sum;
   logic                    sat_hit;
   logic [ACC_W-1:0]        acc_sat;

   assign beat      = in_valid && (state_reg == ACCUM);
   assign last_beat = beat && (count_reg == CNT_W'(N_INPUTS - 1));

   // One extra bit of headroom lets the top two bits of the sum detect overflow.
   assign prod     = $signed(x) * $signed(w);
   assign acc_ext  = {acc_reg[ACC_W-1], acc_reg};
   assign prod_ext = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
   assign sum      = acc_ext + prod_ext;
   assign sat_hit  = sum[ACC_W] != sum[ACC_W-1];

   always_comb begin
      acc_sat = sum[ACC_W-1:0];
      if (sat_hit) begin
         acc_sat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)     state_next = ACCUM;
         ACCUM:   if (last_beat) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == ACCUM);
      out_valid = (state_reg == DONE);
      busy      = (state_reg != IDLE);
      acc_out   = acc_reg;
      overflow  = overflow_reg;
   end

   // Accumulator holds its value in IDLE so the last result stays visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg      <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else if (state_reg == IDLE && start) begin
         acc_reg      <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else if (beat) begin
         acc_reg      <= acc_sat;
         count_reg    <= count_reg + CNT_W'(1);
         overflow_reg <= overflow_reg | sat_hit;
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed checks of neuron_mac against a saturating
// integer accumulation model.
module tb_neuron_mac;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  x;
   logic [7:0]  w;
   logic [15:0] acc_out;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        overflow;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   neuron_mac #(.N_INPUTS(N), .DATA_W(8), .ACC_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .w         (w),
      .acc_out   (acc_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input int observed, input int expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int acc_now();
      return int'($signed(acc_out));
   endfunction

   task automatic run_eval(input int xs[N], input int ws[N], input bit bubbles, input int hold);
      int acc;
      bit ovf;
      int gap;
      acc = 0;
      ovf = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", int'(busy), 1);
      check("start_in_ready", int'(in_ready), 1);
      check("start_acc_clr", acc_now(), 0);
      check("start_ovf_clr", int'(overflow), 0);
      for (int i = 0; i < N; i++) begin
         if (bubbles) begin
            gap = int'($urandom_range(1, 2));
            in_valid = 1'b0;
            x = 8'($urandom);
            w = 8'($urandom);
            repeat (gap) begin
               tick();
               check("bubble_acc", acc_now(), acc);
               check("bubble_out_valid", int'(out_valid), 0);
               check("bubble_in_ready", int'(in_ready), 1);
            end
         end
         x = xs[i][7:0];
         w = ws[i][7:0];
         in_valid = 1'b1;
         acc = acc + xs[i] * ws[i];
         if (acc > 32767) begin
            acc = 32767;
            ovf = 1'b1;
         end else if (acc < -32768) begin
            acc = -32768;
            ovf = 1'b1;
         end
         tick();
         in_valid = 1'b0;
         check("beat_acc", acc_now(), acc);
         check("beat_ovf", int'(overflow), int'(ovf));
         check("beat_out_valid", int'(out_valid), int'(i == N - 1));
      end
      check("done_in_ready", int'(in_ready), 0);
      repeat (hold) begin
         start    = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         x = 8'($urandom);
         w = 8'($urandom);
         out_ready = 1'b0;
         tick();
         check("hold_out_valid", int'(out_valid), 1);
         check("hold_acc", acc_now(), acc);
         check("hold_in_ready", int'(in_ready), 0);
         check("hold_busy", int'(busy), 1);
      end
      // start asserted alongside the handoff must not launch a new evaluation.
      start     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("handoff_busy", int'(busy), 0);
      check("handoff_out_valid", int'(out_valid), 0);
      check("handoff_acc_held", acc_now(), acc);
      tick();
      check("idle_stays_idle", int'(busy), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_acc"}, acc_now(), 0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_in_ready"}, int'(in_ready), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_ovf"}, int'(overflow), 0);
   endtask

   int xa[N];
   int wa[N];
   int held;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      x = '0;
      w = '0;
      tick();
      tick();
      check_reset_state("reset");
      rst_n = 1'b1;
      tick();

      // Basic dot product.
      xa = '{10, 20, 30, 40};
      wa = '{1, 2, 3, 4};
      run_eval(xa, wa, 1'b0, 0);
      check("t1_acc", acc_now(), 300);
      check("t1_ovf", int'(overflow), 0);

      // Beats offered in IDLE are ignored.
      held = acc_now();
      in_valid = 1'b1;
      x = 8'd5;
      w = 8'd5;
      tick();
      in_valid = 1'b0;
      check("idle_beat_busy", int'(busy), 0);
      check("idle_beat_acc", acc_now(), held);

      // Positive saturation that sticks.
      xa = '{-128, -128, -128, -128};
      wa = '{-128, -128, -128, -128};
      run_eval(xa, wa, 1'b0, 0);
      check("t2_acc", acc_now(), 32767);
      check("t2_ovf", int'(overflow), 1);

      // Saturation mid-evaluation then recovery.
      xa = '{-128, -128, -128, -128};
      wa = '{-128, -128, 127, 127};
      run_eval(xa, wa, 1'b0, 0);
      check("t3_acc", acc_now(), 255);
      check("t3_ovf", int'(overflow), 1);

      // Downstream stall in DONE.
      xa = '{10, 20, 30, 40};
      wa = '{1, 2, 3, 4};
      run_eval(xa, wa, 1'b0, 5);
      check("t4_acc", acc_now(), 300);

      // Bubbles between beats.
      run_eval(xa, wa, 1'b1, 0);
      check("t5_acc", acc_now(), 300);
      check("t5_ovf", int'(overflow), 0);

      // Reset mid-evaluation.
      xa = '{-128, -128, 1, 1};
      wa = '{-128, -128, 1, 1};
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         x = xa[i][7:0];
         w = wa[i][7:0];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      check_reset_state("midreset");
      rst_n = 1'b1;
      tick();
      check("midreset_idle", int'(busy), 0);
      xa = '{10, 20, 30, 40};
      wa = '{1, 2, 3, 4};
      run_eval(xa, wa, 1'b0, 0);
      check("t6_acc", acc_now(), 300);
      check("t6_ovf", int'(overflow), 0);

      // Randomized evaluations, biased toward extreme operands.
      for (int e = 0; e < 30; e++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               xa[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
               wa[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
            end else begin
               xa[i] = int'($urandom_range(0, 255)) - 128;
               wa[i] = int'($urandom_range(0, 255)) - 128;
            end
         end
         run_eval(xa, wa, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
